// File: rtl/mmm_pkg.sv
// Shared core-wide widths and the branch type encoding used by the branch path.
package mmm_pkg;

  localparam int XLEN  = 32;
  localparam int HLEN  = 8;
  localparam int B_IMM = 13;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5,
    JAL  = 3'd6,
    JALR = 3'd7
  } branch_type_t;

endpackage

// File: rtl/branch_issue_arbiter.sv
// Round-robin arbiter that shares the single branch unit between N_REQ issue
// lanes, feeding it through a one-entry registered output stage.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. On the lane side req_ready_o is the one-hot grant and is only ever
// raised for a lane whose req_valid_i is 1. On the branch-unit side
// ops_valid_o stays high with a stable bundle until ops_ready_i is seen.
module branch_issue_arbiter
  import mmm_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            flush_i,
  input  logic [N_REQ-1:0]                req_valid_i,
  output logic [N_REQ-1:0]                req_ready_o,
  input  logic [N_REQ-1:0][XLEN-1:0]      req_rs1_i,
  input  logic [N_REQ-1:0][XLEN-1:0]      req_rs2_i,
  input  logic [N_REQ-1:0][B_IMM-1:0]     req_imm_i,
  input  logic [N_REQ-1:0][XLEN-1:0]      req_pc_i,
  input  logic [N_REQ-1:0][HLEN-1:0]      req_index_i,
  input  logic [N_REQ-1:0][XLEN-1:0]      req_target_i,
  input  logic [N_REQ-1:0]                req_taken_i,
  input  branch_type_t [N_REQ-1:0]        req_type_i,
  output logic                            ops_valid_o,
  input  logic                            ops_ready_i,
  output logic [XLEN-1:0]                 rs1_o,
  output logic [XLEN-1:0]                 rs2_o,
  output logic [B_IMM-1:0]                imm_o,
  output logic [XLEN-1:0]                 pc_o,
  output logic [HLEN-1:0]                 index_o,
  output logic [XLEN-1:0]                 target_o,
  output logic                            taken_o,
  output branch_type_t                    type_o,
  output logic [SRC_W-1:0]                src_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

  stage_state_t     state_q, state_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic             load_en;
  logic             grant_found;
  logic [SRC_W-1:0] grant_idx;
  int               scan_idx;

  logic [XLEN-1:0]  rs1_q, rs2_q, pc_q, target_q;
  logic [B_IMM-1:0] imm_q;
  logic [HLEN-1:0]  index_q;
  logic             taken_q;
  branch_type_t     type_q;
  logic [SRC_W-1:0] src_q;

  // The stage can accept a new bundle when empty or when its current one leaves.
  assign load_en     = (state_q == EMPTY) || ops_ready_i;
  assign ops_valid_o = (state_q == FULL);

  // Round-robin search starting at ptr; blocked by reset, flush or a stalled stage.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    req_ready_o = '0;
    if (rst_n_i && load_en && !flush_i) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx = (int'(ptr_q) + k) % N_REQ;
        if (!grant_found && req_valid_i[scan_idx]) begin
          grant_found = 1'b1;
          grant_idx   = SRC_W'(scan_idx);
        end
      end
    end
    if (grant_found) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Pointer advances past the granted lane so it gets lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (N_REQ == 1) begin
      ptr_d = '0;
    end else if (grant_found) begin
      ptr_d = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  // Output stage next state: flush empties it, a grant fills it, a handshake drains it.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (grant_found) begin
      state_d = FULL;
    end else if ((state_q == FULL) && ops_ready_i) begin
      state_d = EMPTY;
    end
  end

  // Stage state and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Payload registers load only on a grant; otherwise the bundle is held.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      index_q  <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
      type_q   <= BEQ;
      src_q    <= '0;
    end else if (grant_found) begin
      rs1_q    <= req_rs1_i[grant_idx];
      rs2_q    <= req_rs2_i[grant_idx];
      imm_q    <= req_imm_i[grant_idx];
      pc_q     <= req_pc_i[grant_idx];
      index_q  <= req_index_i[grant_idx];
      target_q <= req_target_i[grant_idx];
      taken_q  <= req_taken_i[grant_idx];
      type_q   <= req_type_i[grant_idx];
      src_q    <= (N_REQ == 1) ? '0 : grant_idx;
    end
  end

  assign rs1_o    = rs1_q;
  assign rs2_o    = rs2_q;
  assign imm_o    = imm_q;
  assign pc_o     = pc_q;
  assign index_o  = index_q;
  assign target_o = target_q;
  assign taken_o  = taken_q;
  assign type_o   = type_q;
  assign src_o    = src_q;

endmodule

// File: tb/tb_branch_issue_arbiter.sv
// Directed bench for branch_issue_arbiter with N_REQ=2.
module tb_branch_issue_arbiter;
  import mmm_pkg::*;

  localparam int N_REQ = 2;
  localparam int SRC_W = 1;

  logic                        clk;
  logic                        rst_n;
  logic                        flush;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][XLEN-1:0]  req_rs1;
  logic [N_REQ-1:0][XLEN-1:0]  req_rs2;
  logic [N_REQ-1:0][B_IMM-1:0] req_imm;
  logic [N_REQ-1:0][XLEN-1:0]  req_pc;
  logic [N_REQ-1:0][HLEN-1:0]  req_index;
  logic [N_REQ-1:0][XLEN-1:0]  req_target;
  logic [N_REQ-1:0]            req_taken;
  branch_type_t [N_REQ-1:0]    req_type;
  logic                        ops_valid;
  logic                        ops_ready;
  logic [XLEN-1:0]             rs1, rs2, pc, target;
  logic [B_IMM-1:0]            imm;
  logic [HLEN-1:0]             index;
  logic                        taken;
  branch_type_t                btype;
  logic [SRC_W-1:0]            src;

  int tests;
  int fails;

  branch_issue_arbiter #(.N_REQ(N_REQ)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_rs1_i    (req_rs1),
    .req_rs2_i    (req_rs2),
    .req_imm_i    (req_imm),
    .req_pc_i     (req_pc),
    .req_index_i  (req_index),
    .req_target_i (req_target),
    .req_taken_i  (req_taken),
    .req_type_i   (req_type),
    .ops_valid_o  (ops_valid),
    .ops_ready_i  (ops_ready),
    .rs1_o        (rs1),
    .rs2_o        (rs2),
    .imm_o        (imm),
    .pc_o         (pc),
    .index_o      (index),
    .target_o     (target),
    .taken_o      (taken),
    .type_o       (btype),
    .src_o        (src)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: load one lane's bundle fields.
  task automatic set_lane(input int l, input logic [XLEN-1:0] l_pc,
                          input logic [XLEN-1:0] l_rs1, input logic [XLEN-1:0] l_rs2,
                          input branch_type_t l_type);
    req_pc[l]     = l_pc;
    req_rs1[l]    = l_rs1;
    req_rs2[l]    = l_rs2;
    req_type[l]   = l_type;
    req_imm[l]    = B_IMM'(l_pc[7:0]);
    req_index[l]  = HLEN'(l + 3);
    req_target[l] = l_pc + 32'h40;
    req_taken[l]  = l[0];
  endtask

  // Driver: set inputs at the falling edge, settle, leaving the rising edge ahead.
  task automatic drive(input logic [N_REQ-1:0] v, input logic rdy, input logic fl);
    @(negedge clk);
    req_valid = v;
    ops_ready = rdy;
    flush     = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    ops_ready = 1'b1;
    req_valid = 2'b11;
    set_lane(0, 32'h100, 32'd1, 32'd2, BNE);
    set_lane(1, 32'h200, 32'd3, 32'd4, BGE);
    repeat (2) @(negedge clk);
    #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    tests++; if (ops_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ops_valid); end
    tests++; if (src !== 1'b0) begin fails++; $display("FAIL reset_src: got %0d want 0", src); end
    tests++;
    if (pc !== 0 || rs1 !== 0 || rs2 !== 0 || imm !== 0 || index !== 0 || target !== 0 || taken !== 0 || btype !== BEQ) begin
      fails++; $display("FAIL reset_payload: pc=%h rs1=%h rs2=%h imm=%h idx=%h tgt=%h tk=%b ty=%0d want all 0", pc, rs1, rs2, imm, index, target, taken, btype);
    end
    req_valid = 2'b00;
    rst_n = 1'b1;
    drive(2'b00, 1'b1, 1'b0);
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL idle_ready: got %b want 00", req_ready); end
    step();
    tests++; if (ops_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b want 0", ops_valid); end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] exp_g;
    logic [XLEN-1:0]  exp_pc;
    set_lane(0, 32'h100, 32'd11, 32'd12, BNE);
    set_lane(1, 32'h200, 32'd21, 32'd22, BGE);
    for (int i = 0; i < 4; i++) begin
      exp_g  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_pc = (i % 2 == 0) ? 32'h100 : 32'h200;
      drive(2'b11, 1'b1, 1'b0);
      tests++; if (req_ready !== exp_g) begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, exp_g); end
      step();
      tests++;
      if (ops_valid !== 1'b1 || pc !== exp_pc || src !== SRC_W'(i % 2)) begin
        fails++; $display("FAIL rr_out[%0d]: valid=%b pc=%h src=%0d want 1 %h %0d", i, ops_valid, pc, src, exp_pc, i % 2);
      end
    end
    tests++; if (target !== 32'h240 || taken !== 1'b1 || index !== 8'd4) begin
      fails++; $display("FAIL rr_fields: tgt=%h tk=%b idx=%h want 240 1 04", target, taken, index);
    end
    drive(2'b00, 1'b1, 1'b0);
    step();
    tests++; if (ops_valid !== 1'b0) begin fails++; $display("FAIL rr_drain: got %b want 0", ops_valid); end
  endtask

  task automatic test_stall();
    set_lane(1, 32'h300, 32'd5, 32'd7, BLT);
    set_lane(0, 32'h100, 32'd9, 32'd10, BNE);
    drive(2'b10, 1'b1, 1'b0);
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL stall_fill_grant: got %b want 10", req_ready); end
    step();
    tests++; if (ops_valid !== 1'b1 || src !== 1'b1 || rs1 !== 32'd5 || rs2 !== 32'd7 || btype !== BLT) begin
      fails++; $display("FAIL stall_fill: valid=%b src=%0d rs1=%0d rs2=%0d ty=%0d want 1 1 5 7 2", ops_valid, src, rs1, rs2, btype);
    end
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1'b0, 1'b0);
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL stall_ready[%0d]: got %b want 00", i, req_ready); end
      step();
      tests++; if (ops_valid !== 1'b1 || src !== 1'b1 || rs1 !== 32'd5 || rs2 !== 32'd7 || btype !== BLT || pc !== 32'h300) begin
        fails++; $display("FAIL stall_hold[%0d]: valid=%b src=%0d rs1=%0d pc=%h want 1 1 5 300", i, ops_valid, src, rs1, pc);
      end
    end
    drive(2'b01, 1'b1, 1'b0);
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL stall_release: got %b want 01", req_ready); end
    step();
    tests++; if (ops_valid !== 1'b1 || src !== 1'b0 || rs1 !== 32'd9 || btype !== BNE) begin
      fails++; $display("FAIL stall_next: valid=%b src=%0d rs1=%0d want 1 0 9", ops_valid, src, rs1);
    end
    drive(2'b00, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_lane1_only();
    // ptr is 1 on entry; one lane1 grant brings it to 0.
    drive(2'b10, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 1'b1, 1'b0);
      tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL l1_grant[%0d]: got %b want 10", i, req_ready); end
      step();
      tests++; if (src !== 1'b1 || ops_valid !== 1'b1) begin fails++; $display("FAIL l1_src[%0d]: src=%0d valid=%b want 1 1", i, src, ops_valid); end
    end
    drive(2'b11, 1'b1, 1'b0);
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL l1_ptr0: got %b want 01", req_ready); end
    step();
    drive(2'b00, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_flush();
    // ptr is 1 on entry.
    drive(2'b11, 1'b1, 1'b0);
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL fl_fill: got %b want 10", req_ready); end
    step();
    drive(2'b11, 1'b1, 1'b1);
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL fl_nogrant: got %b want 00", req_ready); end
    step();
    tests++; if (ops_valid !== 1'b0) begin fails++; $display("FAIL fl_empty: got %b want 0", ops_valid); end
    drive(2'b11, 1'b1, 1'b0);
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL fl_ptr: got %b want 01", req_ready); end
    step();
    tests++; if (ops_valid !== 1'b1 || src !== 1'b0) begin fails++; $display("FAIL fl_after: valid=%b src=%0d want 1 0", ops_valid, src); end
    drive(2'b00, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_async_reset();
    // ptr is 1 on entry.
    drive(2'b11, 1'b1, 1'b0);
    step();
    tests++; if (ops_valid !== 1'b1 || src !== 1'b1) begin fails++; $display("FAIL ar_fill: valid=%b src=%0d want 1 1", ops_valid, src); end
    req_valid = 2'b00;
    ops_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (ops_valid !== 1'b0 || src !== 1'b0 || pc !== 0) begin
      fails++; $display("FAIL ar_clear: valid=%b src=%0d pc=%h want 0 0 0", ops_valid, src, pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 1'b1, 1'b0);
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL ar_first: got %b want 01", req_ready); end
    step();
    tests++; if (src !== 1'b0 || ops_valid !== 1'b1) begin fails++; $display("FAIL ar_out: src=%0d valid=%b want 0 1", src, ops_valid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_round_robin();
    test_stall();
    test_lane1_only();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_issue_arbiter.md
Name: branch_issue_arbiter

Overview:
- Shares the single branch unit between N_REQ issue lanes.
- Each cycle, a round-robin arbiter picks at most one valid branch bundle (operands, immediate, prediction metadata, branch type) and loads it into a one-entry output stage.
- The output stage drives the branch unit's operand inputs under a valid/ready handshake.
- Sits between the issue/dispatch lanes and the branch unit; flushed on mispredict.

Parameters:
- N_REQ, 2, number of requesting issue lanes (>=1).
- SRC_W, max(1,$clog2(N_REQ)), width of the granted-source index.
- XLEN, HLEN, B_IMM and branch_type_t are taken from mmm_pkg.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous pipeline flush (mispredict/exception).
- req_valid_i  in  N_REQ  lane i holds a branch ready for execution.
- req_ready_o  out  N_REQ  one-hot grant; lane i's bundle is taken this cycle.
- req_rs1_i  in  N_REQ x XLEN  operand 1 per lane.
- req_rs2_i  in  N_REQ x XLEN  operand 2 per lane.
- req_imm_i  in  N_REQ x B_IMM  branch offset per lane.
- req_pc_i  in  N_REQ x XLEN  branch PC per lane.
- req_index_i  in  N_REQ x HLEN  predictor history index per lane.
- req_target_i  in  N_REQ x XLEN  predicted target per lane.
- req_taken_i  in  N_REQ  predicted direction per lane.
- req_type_i  in  N_REQ x branch_type_t  branch type per lane.
- ops_valid_o  out  1  output stage holds a bundle for the branch unit.
- ops_ready_i  in  1  branch unit accepts the bundle.
- rs1_o  out  XLEN  registered bundle field.
- rs2_o  out  XLEN  registered bundle field.
- imm_o  out  B_IMM  registered bundle field.
- pc_o  out  XLEN  registered bundle field.
- index_o  out  HLEN  registered bundle field.
- target_o  out  XLEN  registered bundle field.
- taken_o  out  1  registered bundle field.
- type_o  out  branch_type_t  registered bundle field.
- src_o  out  SRC_W  lane index of the held bundle, used to route the result.

Behaviour:
- Reset (async, rst_n_i=0):
  - ops_valid_o=0, ptr=0.
  - All payload outputs and src_o = 0; type_o = beq.
  - req_ready_o=0 combinationally while in reset.
- Output stage is a two-state FSM, EMPTY (ops_valid_o=0) and FULL (ops_valid_o=1).
  - load_en = !ops_valid_o || ops_ready_i (full-throughput pipeline register).
- Arbitration (combinational, same cycle):
  - If load_en && !flush_i, grant the first lane i with req_valid_i[i]=1, searching ptr, ptr+1, ... modulo N_REQ.
  - req_ready_o is one-hot or zero. A lane is never granted when its req_valid_i=0.
  - req_ready_o does not depend on req_valid_i of the granted lane's own readiness beyond this rule. There is no combinational path from ops_ready_i to req_ready_o other than through load_en.
- On a grant to lane g at a clock edge:
  - Payload registers load lane g's fields; src_o<=g; ops_valid_o<=1.
  - ptr<=(g+1) mod N_REQ.
- No grant and ops_ready_i=1 while FULL: ops_valid_o<=0, payload held.
- FULL and ops_ready_i=0: all outputs held stable; no grant.
- Latency: 1 cycle from grant to ops_valid_o. Back-to-back issue every cycle while ops_ready_i=1.
- Fairness: a continuously requesting lane waits at most N_REQ-1 grants.
- flush_i=1 (has priority over all other events):
  - ops_valid_o<=0; no grant that cycle (req_ready_o=0).
  - ptr unchanged; payload may hold stale data.
- Simultaneous ops_ready_i handshake and flush: the handshake completes (the branch unit takes the bundle) and the stage becomes EMPTY.
- N_REQ=1: ptr is constant 0 and src_o=0; behaviour otherwise identical.
- Reset asserted mid-operation: immediate clear as above. No bundle survives reset.

Test Plan:
- Reset then idle -> ops_valid_o=0, req_ready_o=2'b00, src_o=0, all payload outputs 0.
- N_REQ=2, ops_ready_i=1, both lanes valid for 4 cycles (lane0 pc=0x100, lane1 pc=0x200) -> grants 01,10,01,10; pc_o sequence 0x100,0x200,0x100,0x200 one cycle after each grant; src_o 0,1,0,1.
- Stage FULL with lane1 bundle (rs1=5, rs2=7, type=blt), ops_ready_i=0 for 3 cycles, lane0 valid -> req_ready_o=00 and outputs stable for 3 cycles; lane0 granted in the cycle ops_ready_i returns to 1.
- Only lane1 valid repeatedly with ptr=0 -> lane1 granted every cycle; ptr stays 0 after each grant.
- flush_i=1 while FULL and both lanes valid -> next cycle ops_valid_o=0, no grant in the flush cycle, ptr unchanged; following cycle grants per the unchanged ptr.
- rst_n_i dropped asynchronously while FULL (src_o=1) -> ops_valid_o=0 and src_o=0 without waiting for a clock edge; first grant after release goes to lane0.
